cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the Common Data Bus among N functional-unit requesters: adder reservation stations, load unit and store unit.
- Grants at most one requester per cycle.
- Registers the winner's tag, data and write-enable onto the bus, which drives the FP register file write port and snooping reservation stations.
- Returns a one-cycle ack to the winner so it can free its station.

Parameters:
- N_REQ, 4, number of requesters (index 0..N_REQ-1).
- DATA_W, 16, CDB data width.
- TAG_W, 3, destination register address width (R0..R7).
- CNT_W, 16, broadcast counter width.

Ports:
- clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester broadcast request; level, held until ack.
- req_we  in  N_REQ  per-requester: 1 = write register file (ADD.D/SUB.D/L.D), 0 = no register write (S.D completion).
- req_tag  in  N_REQ*TAG_W  packed destination tags; slice i belongs to requester i.
- req_data  in  N_REQ*DATA_W  packed result data.
- cdb_stall  in  1  consumer cannot accept; freeze the bus.
- ack  out  N_REQ  one-hot; pulses for exactly the cycle the requester's broadcast is on the bus.
- cdb_valid  out  1  bus carries a broadcast this cycle.
- cdb_we  out  1  register-file write enable (cdb_valid & latched req_we).
- cdb_tag  out  TAG_W  broadcast destination.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  clog2(N_REQ)  index of the winning requester.
- cdb_count  out  CNT_W  number of completed broadcasts.

Behaviour:
- Reset (Reset=0, asynchronous):
  - ack=0, cdb_valid=0, cdb_we=0, cdb_tag=0, cdb_data=0, cdb_src=0, cdb_count=0.
  - Round-robin pointer = 0.
  - Takes effect mid-broadcast; an in-flight broadcast is dropped and the requester re-requests after reset.
- States:
  - IDLE (cdb_valid=0) and BCAST (cdb_valid=1). The state is cdb_valid itself.
- Eligibility at each rising edge with cdb_stall=0: eligible = req & ~ack.
  - Masking the currently acked requester avoids a double grant while it drops req.
- Grant selection:
  - Round-robin: search starts at ptr; the first eligible index wins.
  - ptr <= winner+1, wrapping from N_REQ-1 to 0.
- Latency:
  - req asserted before edge k gives cdb_valid/ack at the earliest in cycle k (registered outputs, 1 cycle).
  - Tag, data and we are captured from the winner's slices at that edge.
- Requester rule:
  - Hold req, req_tag, req_data, req_we stable until ack is seen.
  - Deassert req at the edge ending the ack cycle.
  - req re-asserted later is a new request.
- No eligible requester: next state IDLE; cdb_valid=0, ack=0; tag/data hold their last values.
- Back-to-back: different requesters may win on consecutive cycles. The same requester wins again only after one intervening edge.
- cdb_stall=1 at an edge:
  - All outputs hold, including ack, which stays high.
  - ptr holds and no new grant is made.
  - The broadcast completes at the first non-stalled edge.
- cdb_count increments by 1 at each edge where cdb_valid=1 and cdb_stall=0; wraps from 2^CNT_W-1 to 0.
- Requests that arrive simultaneously are resolved purely by ptr. A req dropped without ack is a protocol error; the bench flags it and the arbiter does not detect it.

Optional Feature:
- Macro: CDB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. ptr is not implemented and eligibility is otherwise unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package cdb_pkg:
  - DATA_W/TAG_W defaults.
  - Opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_LD=4'b0010, OP_SD=4'b0011 for requester-side req_we decode.
  - cdb_bus_t struct {valid, we, tag, data}.
- Sub-module rr_arbiter:
  - Combinational one-hot pick from eligible + ptr.
  - Also contains the pointer register and the macro-selected fixed-priority path.
- cdb_arbiter holds the output registers, stall hold and counter.

Test Plan:
- Reset release, no req → cdb_valid=0, ack=0 and cdb_count=0 for 10 cycles.
- Single req[2]=1, tag=5, data=16'h3C00, we=1 → next cycle cdb_valid=1, cdb_we=1, cdb_tag=5, cdb_data=16'h3C00, ack=4'b0100; requester drops req → IDLE; count=1.
- req=4'b1111 held continuously (re-asserted after each ack) → grant order 0,1,2,3,0, one per cycle with no gaps; with CDB_FIXED_PRIO_EN, same stimulus after ack drop → 0,1,0,1 while 0 and 1 keep requesting.
- S.D requester req[3], we=0, tag=2 → cdb_valid=1, cdb_we=0, ack[3]=1.
- Broadcast of req[1], then cdb_stall=1 for 3 cycles → outputs and ack[1] frozen 4 cycles total; count increments once, after stall release.
- Reset pulled low mid-BCAST (asynchronously, between edges) → cdb_valid and ack go 0 immediately; after release, the held req[0] is granted one cycle later.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and constants for the Common Data Bus arbiter and its requesters.
package cdb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int TAG_W_DEF  = 3;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_SD  = 4'b0011;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BCAST = 1'b1
   } cdb_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [TAG_W_DEF-1:0]  tag;
      logic [DATA_W_DEF-1:0] data;
   } cdb_bus_t;

   // Requester-side decode: only a store completes without a register write.
   function automatic logic op_writes_rf(input logic [3:0] op);
      return op != OP_SD;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant picker with round-robin pointer.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no pointer).
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_elig,
   input  logic             i_advance,
   output logic [N_REQ-1:0] o_gnt,
   output logic [SRC_W-1:0] o_idx,
   output logic             o_any
);

   logic [N_REQ-1:0] w_gnt;
   logic [SRC_W-1:0] w_idx;
   logic             w_any;

`ifdef CDB_FIXED_PRIO_EN
   logic w_unused;
   assign w_unused = ^{i_clk, i_rst_n, i_advance};

   always_comb begin
      w_gnt = '0;
      w_idx = '0;
      w_any = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!w_any && i_elig[SRC_W'(i)]) begin
            w_any              = 1'b1;
            w_idx              = SRC_W'(i);
            w_gnt[SRC_W'(i)]   = 1'b1;
         end
      end
   end
`else
   logic [SRC_W-1:0] r_ptr;
   logic [SRC_W:0]   w_sum;
   logic [SRC_W-1:0] w_k;

   // Scan from the pointer, wrapping the index without a modulo operator.
   always_comb begin
      w_gnt = '0;
      w_idx = '0;
      w_any = 1'b0;
      w_sum = '0;
      w_k   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + (SRC_W+1)'(i);
         if (w_sum >= (SRC_W+1)'(N_REQ))
            w_sum = w_sum - (SRC_W+1)'(N_REQ);
         w_k = w_sum[SRC_W-1:0];
         if (!w_any && i_elig[w_k]) begin
            w_any       = 1'b1;
            w_idx       = w_k;
            w_gnt[w_k]  = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ptr <= '0;
      else if (i_advance)
         r_ptr <= (w_idx == SRC_W'(N_REQ-1)) ? '0 : w_idx + SRC_W'(1);
   end
`endif

   assign o_gnt = w_gnt;
   assign o_idx = w_idx;
   assign o_any = w_any;

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: registers one winning requester per cycle onto the bus.
// Optional macro CDB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic [N_REQ-1:0]                          i_req,
   input  logic [N_REQ-1:0]                          i_req_we,
   input  logic [N_REQ*TAG_W-1:0]                    i_req_tag,
   input  logic [N_REQ*DATA_W-1:0]                   i_req_data,
   input  logic                                      i_cdb_stall,
   output logic [N_REQ-1:0]                          o_ack,
   output logic                                      o_cdb_valid,
   output logic                                      o_cdb_we,
   output logic [TAG_W-1:0]                          o_cdb_tag,
   output logic [DATA_W-1:0]                         o_cdb_data,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] o_cdb_src,
   output logic [CNT_W-1:0]                          o_cdb_count
);

   localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   cdb_state_t        r_state, w_state_nxt;
   logic [N_REQ-1:0]  r_ack;
   logic [N_REQ-1:0]  w_elig;
   logic [N_REQ-1:0]  w_gnt;
   logic [SRC_W-1:0]  w_idx;
   logic              w_any;
   logic              w_advance;
   logic [SRC_W-1:0]  r_src;
   logic              r_we;
   logic [TAG_W-1:0]  r_tag;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_cnt;

   // The acked requester is still holding req this cycle; masking it prevents a re-grant.
   assign w_elig    = i_req & ~r_ack;
   assign w_advance = ~i_cdb_stall & w_any;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .SRC_W (SRC_W)
   ) u_arb (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_elig    (w_elig),
      .i_advance (w_advance),
      .o_gnt     (w_gnt),
      .o_idx     (w_idx),
      .o_any     (w_any)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_cdb_stall)
         w_state_nxt = w_any ? ST_BCAST : ST_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ack  <= '0;
         r_src  <= '0;
         r_we   <= 1'b0;
         r_tag  <= '0;
         r_data <= '0;
         r_cnt  <= '0;
      end else if (!i_cdb_stall) begin
         r_ack <= w_gnt;
         if (r_state == ST_BCAST)
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_any) begin
            r_src  <= w_idx;
            r_we   <= i_req_we[w_idx];
            r_tag  <= i_req_tag[w_idx*TAG_W +: TAG_W];
            r_data <= i_req_data[w_idx*DATA_W +: DATA_W];
         end
      end
   end

   assign o_ack       = r_ack;
   assign o_cdb_valid = (r_state == ST_BCAST);
   assign o_cdb_we    = (r_state == ST_BCAST) & r_we;
   assign o_cdb_tag   = r_tag;
   assign o_cdb_data  = r_data;
   assign o_cdb_src   = r_src;
   assign o_cdb_count = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model of the bus.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int TW = 3;
   localparam int CW = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [N-1:0]     req = '0;
   logic [N-1:0]     req_we = '0;
   logic [N*TW-1:0]  req_tag = '0;
   logic [N*DW-1:0]  req_data = '0;
   logic             stall = 1'b0;
   logic [N-1:0]     o_ack;
   logic             o_cdb_valid;
   logic             o_cdb_we;
   logic [TW-1:0]    o_cdb_tag;
   logic [DW-1:0]    o_cdb_data;
   logic [1:0]       o_cdb_src;
   logic [CW-1:0]    o_cdb_count;

   cdb_arbiter #(
      .N_REQ  (N),
      .DATA_W (DW),
      .TAG_W  (TW),
      .CNT_W  (CW)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_req_we    (req_we),
      .i_req_tag   (req_tag),
      .i_req_data  (req_data),
      .i_cdb_stall (stall),
      .o_ack       (o_ack),
      .o_cdb_valid (o_cdb_valid),
      .o_cdb_we    (o_cdb_we),
      .o_cdb_tag   (o_cdb_tag),
      .o_cdb_data  (o_cdb_data),
      .o_cdb_src   (o_cdb_src),
      .o_cdb_count (o_cdb_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 0;
   bit rand_mode = 0;
   logic [N-1:0] keep = '0;

   // Model of what must be on the bus
   cdb_bus_t     m_bus;
   logic [N-1:0] m_ack;
   int           m_src;
   int           m_ptr;
   logic [CW-1:0] m_cnt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_bus = '0;
      m_ack = '0;
      m_src = 0;
      m_ptr = 0;
      m_cnt = '0;
   endtask

   // Outcome of one clock edge, given the requests present just before it
   task automatic model_edge(input bit s);
      logic [N-1:0] el;
      int w;
      if (s) return;
      el = req & ~m_ack;
      w = -1;
      for (int off = 0; off < N; off++) begin
         int k;
         k = (m_ptr + off) % N;
         if (w < 0 && el[k]) w = k;
      end
      if (m_bus.valid) m_cnt = m_cnt + 16'd1;
      m_ack = '0;
      if (w >= 0) begin
         m_bus.valid = 1'b1;
         m_bus.we    = req_we[w];
         m_bus.tag   = req_tag[w*TW +: TW];
         m_bus.data  = req_data[w*DW +: DW];
         m_src       = w;
         m_ack[w]    = 1'b1;
`ifndef CDB_FIXED_PRIO_EN
         m_ptr       = (w + 1) % N;
`endif
      end else begin
         m_bus.valid = 1'b0;
      end
   endtask

   task automatic new_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d,
                          input logic [3:0] op);
      req[i]               = 1'b1;
      req_we[i]            = op_writes_rf(op);
      req_tag[i*TW +: TW]  = t;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic rand_req(input int i);
      new_req(i, TW'($urandom_range(0, 7)), DW'($urandom), 4'($urandom_range(0, 3)));
   endtask

   // One clock: model follows the edge, then requesters react to its acks
   task automatic cycle();
      logic [N-1:0] a0, done;
      bit s0;
      a0 = m_ack;
      s0 = stall;
      @(posedge clk);
      if (rst_n) model_edge(s0);
      #1;
      done = s0 ? '0 : a0;
      for (int i = 0; i < N; i++) begin
         if (done[i]) begin
            if (rand_mode ? ($urandom_range(0, 99) < 40) : keep[i]) rand_req(i);
            else req[i] = 1'b0;
         end else if (rand_mode && !req[i] && $urandom_range(0, 99) < 30) begin
            rand_req(i);
         end
      end
      if (rand_mode) stall = ($urandom_range(0, 99) < 15);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      req = '0;
      stall = 1'b0;
      keep = '0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", o_cdb_valid, m_bus.valid);
         chk("ack",   o_ack,       m_ack);
         chk("we",    o_cdb_we,    m_bus.valid & m_bus.we);
         chk("tag",   o_cdb_tag,   m_bus.tag);
         chk("data",  o_cdb_data,  m_bus.data);
         chk("src",   o_cdb_src,   64'(m_src));
         chk("count", o_cdb_count, m_cnt);
      end
   end

   int seq [5];
`ifdef CDB_FIXED_PRIO_EN
   int exp_seq [5] = '{0, 1, 0, 1, 0};
`else
   int exp_seq [5] = '{0, 1, 2, 3, 0};
`endif
   logic [CW-1:0] c0;

   initial begin
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_en = 1;
      do_reset();

      // Idle after reset
      repeat (10) cycle();
      chk("idle_valid", o_cdb_valid, 1'b0);
      chk("idle_count", o_cdb_count, 16'd0);

      // Single requester 2
      new_req(2, 3'd5, 16'h3C00, OP_ADD);
      cycle();
      chk("single_valid", o_cdb_valid, 1'b1);
      chk("single_we",    o_cdb_we,    1'b1);
      chk("single_tag",   o_cdb_tag,   3'd5);
      chk("single_data",  o_cdb_data,  16'h3C00);
      chk("single_ack",   o_ack,       4'b0100);
      cycle();
      chk("single_idle",  o_cdb_valid, 1'b0);
      chk("single_count", o_cdb_count, 16'd1);

      // All four requesting continuously
      do_reset();
      keep = '1;
      for (int i = 0; i < N; i++) rand_req(i);
      for (int j = 0; j < 5; j++) begin
         cycle();
         seq[j] = int'(o_cdb_src);
         chk("b2b_valid", o_cdb_valid, 1'b1);
      end
      for (int j = 0; j < 5; j++) chk($sformatf("grant_order_%0d", j), 64'(seq[j]), 64'(exp_seq[j]));
      keep = '0;
      repeat (8) cycle();

      // Store completion: no register write
      new_req(3, 3'd2, 16'h1234, OP_SD);
      cycle();
      chk("sd_valid", o_cdb_valid, 1'b1);
      chk("sd_we",    o_cdb_we,    1'b0);
      chk("sd_tag",   o_cdb_tag,   3'd2);
      chk("sd_ack",   o_ack,       4'b1000);
      cycle();

      // Stall holds the broadcast of requester 1
      new_req(1, 3'd6, 16'hBEEF, OP_LD);
      cycle();
      chk("stall_ack0", o_ack, 4'b0010);
      c0 = o_cdb_count;
      stall = 1'b1;
      repeat (3) begin
         cycle();
         chk("stall_ack",   o_ack,       4'b0010);
         chk("stall_valid", o_cdb_valid, 1'b1);
         chk("stall_data",  o_cdb_data,  16'hBEEF);
         chk("stall_count", o_cdb_count, c0);
      end
      stall = 1'b0;
      cycle();
      chk("release_count", o_cdb_count, c0 + 16'd1);
      chk("release_ack",   o_ack,       4'b0000);
      chk("release_valid", o_cdb_valid, 1'b0);

      // Asynchronous reset in the middle of a broadcast
      new_req(0, 3'd1, 16'h5555, OP_SUB);
      cycle();
      chk("pre_rst_ack", o_ack, 4'b0001);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_valid", o_cdb_valid, 1'b0);
      chk("async_rst_ack",   o_ack,       4'b0000);
      chk("async_rst_count", o_cdb_count, 16'd0);
      #2;
      rst_n = 1'b1;
      cycle();
      chk("post_rst_ack",   o_ack,       4'b0001);
      chk("post_rst_valid", o_cdb_valid, 1'b1);
      cycle();

      // Randomized traffic with random stalls
      rand_mode = 1;
      repeat (3000) cycle();
      rand_mode = 0;
      stall = 1'b0;
      repeat (12) cycle();

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
